// File: rtl/alu_lab_pkg.sv
// Shared definitions for the ALU lab operand-entry front end:
// phase encodings, default sizing and the button-event record.
package alu_lab_pkg;

  localparam int WIDTH_DEF         = 4;
  localparam int LED_STRETCH_DEF   = 8;
  localparam int REPEAT_DELAY_DEF  = 16;
  localparam int REPEAT_PERIOD_DEF = 4;

  // Phase encodings; 2'd3 is never entered on purpose.
  localparam logic [1:0] ST_ENTER_A = 2'd0;
  localparam logic [1:0] ST_ENTER_B = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  localparam int NUM_BTN = 3;
  localparam int BTN_INC = 0;

  // Bit order matches {clearBtn, saveBtn, incrementBtn}.
  typedef struct packed {
    logic clr;
    logic save;
    logic inc;
  } btn_evt_t;

  // Keep only the highest-priority event: clear > save > increment.
  function automatic btn_evt_t resolve_prio(input btn_evt_t e);
    btn_evt_t r;
    r.clr  = e.clr;
    r.save = e.save & ~e.clr;
    r.inc  = e.inc & ~e.save & ~e.clr;
    return r;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer plus rising-edge detector for one raw
// push-button. All history flops reset to 1, so a button held through reset
// must be released and pressed again before it produces an event.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic press
);

  logic s1, s2, prev;

  // Synchronize, then register a one-cycle pulse on each 0->1 transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      prev  <= 1'b1;
      press <= 1'b0;
    end else begin
      s1    <= pin;
      s2    <= s1;
      prev  <= s2;
      press <= s2 & ~prev;
    end
  end

  assign level = s2;

endmodule

// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl: turns three raw push-buttons into operand entry for
// the ALU. Increment builds A then B, save steps ENTER_A -> ENTER_B -> RUN
// (latching opCode/cIn and pulsing aluStart), clear zeroes everything.
// Optional feature: define AUTO_REPEAT_EN to auto-repeat a held increment.
module operand_entry_ctrl
  import alu_lab_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int LED_STRETCH   = LED_STRETCH_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic             in_clk,
  input  logic             reset_n,
  input  logic             incrementBtn,
  input  logic             saveBtn,
  input  logic             clearBtn,
  input  logic [3:0]       opCode,
  input  logic             cIn,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [3:0]       opLatched,
  output logic             cInLatched,
  output logic             aluStart,
  output logic [1:0]       state,
  output logic             btnPressLED
);

  localparam int LW = $clog2(LED_STRETCH + 1);

  logic [NUM_BTN-1:0] btn_pin, btn_lvl, btn_raw;
  btn_evt_t           evt;
  logic               rep_fire;
  logic               inc_go;
  logic [LW-1:0]      led_cnt;
  logic               unused_btn_lvl;

  assign btn_pin = {clearBtn, saveBtn, incrementBtn};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_sync_edge u_btn (
      .clk   (in_clk),
      .rst_n (reset_n),
      .pin   (btn_pin[i]),
      .level (btn_lvl[i]),
      .press (btn_raw[i])
    );
  end

  // Only the increment level feeds logic (and only with auto-repeat).
  assign unused_btn_lvl = ^btn_lvl;

  assign evt    = resolve_prio(btn_evt_t'(btn_raw));
  assign inc_go = evt.inc | rep_fire;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_armed;

  // Repeats only count while the button is still held and only matter in
  // the two entry phases; save/clear in the same cycle still win in the FSM.
  assign rep_fire = rep_armed & btn_lvl[BTN_INC] & (rep_cnt == '0) &
                    ((state == ST_ENTER_A) | (state == ST_ENTER_B));

  // Hold timer: initial delay after the press, then a fixed period.
  always_ff @(posedge in_clk) begin
    if (!reset_n) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (!btn_lvl[BTN_INC]) begin
      rep_armed <= 1'b0;
    end else if (btn_raw[BTN_INC]) begin
      rep_armed <= 1'b1;
      rep_cnt   <= RW'(REPEAT_DELAY - 1);
    end else if (evt.save | evt.clr) begin
      rep_cnt   <= RW'(REPEAT_DELAY - 1);
    end else if (rep_armed) begin
      if (rep_cnt == '0) rep_cnt <= RW'(REPEAT_PERIOD - 1);
      else               rep_cnt <= rep_cnt - 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
  assign rep_fire   = 1'b0;
`endif

  // Press indicator: any raw press event (even an ignored one) reloads.
  always_ff @(posedge in_clk) begin
    if (!reset_n)         led_cnt <= '0;
    else if (|btn_raw)    led_cnt <= LW'(LED_STRETCH);
    else if (led_cnt != '0) led_cnt <= led_cnt - 1'b1;
  end

  assign btnPressLED = (led_cnt != '0);

  // Phase FSM and operand/latch registers; aluStart is a one-cycle pulse.
  always_ff @(posedge in_clk) begin
    if (!reset_n) begin
      state      <= ST_ENTER_A;
      A          <= '0;
      B          <= '0;
      opLatched  <= '0;
      cInLatched <= 1'b0;
      aluStart   <= 1'b0;
    end else begin
      aluStart <= 1'b0;
      if (state == 2'd3) begin
        state <= ST_ENTER_A;
      end else if (evt.clr) begin
        state      <= ST_ENTER_A;
        A          <= '0;
        B          <= '0;
        opLatched  <= '0;
        cInLatched <= 1'b0;
      end else if (evt.save) begin
        case (state)
          ST_ENTER_A: state <= ST_ENTER_B;
          ST_ENTER_B: begin
            state      <= ST_RUN;
            opLatched  <= opCode;
            cInLatched <= cIn;
            aluStart   <= 1'b1;
          end
          default:    state <= ST_ENTER_A;
        endcase
      end else if (inc_go) begin
        case (state)
          ST_ENTER_A: A <= A + 1'b1;
          ST_ENTER_B: B <= B + 1'b1;
          default:    ;
        endcase
      end
    end
  end

endmodule
